// File: rtl/axi_llc_plru_bist_ctrl.sv
// axi_llc_plru_bist_ctrl
//   Initiator side of the PLRU BIST handshake towards the eviction box.
//   Requests a PLRU memory self-test on start_i, folds the per-index way
//   fault masks into a summary (faulty-way mask, first failing index,
//   saturating fault count) and reports pass/fail when the end-of-test
//   beat arrives.
//
//   Optional feature: define AXI_LLC_PLRU_BIST_TIMEOUT_EN to build a
//   watchdog that aborts the test after TimeoutCycles idle RUN cycles.
//   Without it, timeout_o is tied low and RUN waits for the eoc beat.
//
// Handshake: plru_gen_valid_o is held high for the whole RUN phase. A
// result beat is transferred in every cycle where plru_gen_valid_o and
// plru_gen_ready_i are both high; plru_bist_res_i and plru_gen_eoc_i are
// only meaningful in such a cycle and are ignored otherwise.
module axi_llc_plru_bist_ctrl #(
    parameter int unsigned SetAssociativity = 8,
    parameter int unsigned NumLines         = 256,
    parameter int unsigned TimeoutCycles    = 1024,
    parameter int unsigned IdxW             = (NumLines > 1) ? $clog2(NumLines) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    output logic                        plru_gen_valid_o,
    input  logic                        plru_gen_ready_i,
    input  logic [SetAssociativity-1:0] plru_bist_res_i,
    input  logic                        plru_gen_eoc_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic [SetAssociativity-1:0] fault_way_o,
    output logic [IdxW-1:0]             fault_idx_o,
    output logic [IdxW:0]               fault_cnt_o,
    output logic                        timeout_o,
    output logic [1:0]                  dbg_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IdxW:0] CNT_MAX = '1;

    // Configuration sanity checks at elaboration time.
    if (SetAssociativity < 2) begin : g_bad_sa
        $error("SetAssociativity must be at least 2");
    end
    if (TimeoutCycles < 1) begin : g_bad_to
        $error("TimeoutCycles must be at least 1");
    end

    logic [1:0]                  state_q;
    logic [SetAssociativity-1:0] fault_way_q;
    logic [IdxW-1:0]             fault_idx_q;
    logic [IdxW:0]               fault_cnt_q;
    logic [IdxW-1:0]             idx_q;
    logic                        pass_q;

    logic                        beat;
    logic                        res_nz;
    logic [SetAssociativity-1:0] way_next;
    logic                        timeout_hit;

    // A beat only exists while the request is actually being driven.
    assign beat     = (state_q == ST_RUN) && plru_gen_ready_i;
    assign res_nz   = |plru_bist_res_i;
    assign way_next = fault_way_q | plru_bist_res_i;

`ifdef AXI_LLC_PLRU_BIST_TIMEOUT_EN
    logic [31:0] to_cnt_q;
    logic        timeout_q;

    // A beat in the same cycle as the expiry wins over the timeout.
    assign timeout_hit = (state_q == ST_RUN) && !plru_gen_ready_i &&
                         ((to_cnt_q + 32'd1) >= TimeoutCycles);

    // Idle-cycle watchdog: counts RUN cycles without a beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= 32'd0;
        end else if (state_q == ST_IDLE && start_i) begin
            to_cnt_q <= 32'd0;
        end else if (state_q == ST_RUN) begin
            if (plru_gen_ready_i) begin
                to_cnt_q <= 32'd0;
            end else begin
                to_cnt_q <= to_cnt_q + 32'd1;
            end
        end
    end

    // Timeout flag: cleared on start, set when the watchdog aborts RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_q <= 1'b0;
        end else if (state_q == ST_IDLE && start_i) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // Sequencer: IDLE -> RUN on start, RUN -> DONE on eoc beat or timeout,
    // DONE -> IDLE after one cycle; pass is resolved on the way into DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        pass_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (beat && plru_gen_eoc_i) begin
                        state_q <= ST_DONE;
                        pass_q  <= (way_next == '0);
                    end else if (timeout_hit) begin
                        state_q <= ST_DONE;
                        pass_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Result accumulation: cleared on start, updated on every RUN beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_way_q <= '0;
            fault_idx_q <= '0;
            fault_cnt_q <= '0;
            idx_q       <= '0;
        end else if (state_q == ST_IDLE && start_i) begin
            fault_way_q <= '0;
            fault_idx_q <= '0;
            fault_cnt_q <= '0;
            idx_q       <= '0;
        end else if (beat) begin
            fault_way_q <= way_next;
            idx_q       <= idx_q + IdxW'(1);
            if (res_nz) begin
                // The count saturates, so zero still means "no fault seen yet".
                if (fault_cnt_q == '0) begin
                    fault_idx_q <= idx_q;
                end
                if (fault_cnt_q != CNT_MAX) begin
                    fault_cnt_q <= fault_cnt_q + (IdxW + 1)'(1);
                end
            end
        end
    end

    assign plru_gen_valid_o = (state_q == ST_RUN);
    assign busy_o           = (state_q == ST_RUN);
    assign done_o           = (state_q == ST_DONE);
    assign pass_o           = pass_q;
    assign fault_way_o      = fault_way_q;
    assign fault_idx_o      = fault_idx_q;
    assign fault_cnt_o      = fault_cnt_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_axi_llc_plru_bist_ctrl.sv
// tb_axi_llc_plru_bist_ctrl
//   Directed bench for axi_llc_plru_bist_ctrl with SetAssociativity=8,
//   NumLines=4, TimeoutCycles=16. Inputs change on the falling edge,
//   outputs are checked on the falling edge after the rising edge that
//   consumed them. Build with AXI_LLC_PLRU_BIST_TIMEOUT_EN to exercise
//   the watchdog.
module tb_axi_llc_plru_bist_ctrl;

    localparam int SA   = 8;
    localparam int NL   = 4;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            valid;
    logic            ready = 1'b0;
    logic [SA-1:0]   res = '0;
    logic            eoc = 1'b0;
    logic            busy;
    logic            done;
    logic            pass;
    logic [SA-1:0]   fway;
    logic [IDXW-1:0] fidx;
    logic [IDXW:0]   fcnt;
    logic            tmo;
    logic [1:0]      st;

    int checks = 0;
    int errors = 0;

    axi_llc_plru_bist_ctrl #(
        .SetAssociativity(SA),
        .NumLines(NL),
        .TimeoutCycles(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .plru_gen_valid_o(valid),
        .plru_gen_ready_i(ready),
        .plru_bist_res_i(res),
        .plru_gen_eoc_i(eoc),
        .busy_o(busy),
        .done_o(done),
        .pass_o(pass),
        .fault_way_o(fway),
        .fault_idx_o(fidx),
        .fault_cnt_o(fcnt),
        .timeout_o(tmo),
        .dbg_state_o(st)
    );

    always #5 clk = ~clk;

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [SA-1:0] r, input logic e);
        ready = 1'b1;
        res   = r;
        eoc   = e;
        @(negedge clk);
        ready = 1'b0;
        res   = '0;
        eoc   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", tmo); end
        checks++; if (fway !== 8'h00) begin errors++; $display("FAIL reset_fway got %h exp 00", fway); end
        checks++; if (fidx !== 2'd0) begin errors++; $display("FAIL reset_fidx got %0d exp 0", fidx); end
        checks++; if (fcnt !== 3'd0) begin errors++; $display("FAIL reset_fcnt got %0d exp 0", fcnt); end
        checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean();
        start_pulse();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL clean_valid_up got %b exp 1", valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_up got %b exp 1", busy); end
        for (int i = 0; i < 3; i++) begin
            beat(8'h00, 1'b0);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL clean_early_done beat %0d got %b exp 0", i, done); end
        end
        beat(8'h00, 1'b1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clean_done got %b exp 1", done); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass got %b exp 1", pass); end
        checks++; if (fway !== 8'h00) begin errors++; $display("FAIL clean_fway got %h exp 00", fway); end
        checks++; if (fcnt !== 3'd0) begin errors++; $display("FAIL clean_fcnt got %0d exp 0", fcnt); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clean_valid_down got %b exp 0", valid); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clean_done_pulse got %b exp 0", done); end
        checks++; if (st !== 2'd0) begin errors++; $display("FAIL clean_idle got %0d exp 0", st); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass_hold got %b exp 1", pass); end
    endtask

    task automatic test_faulty();
        start_pulse();
        beat(8'h00, 1'b0);
        beat(8'h04, 1'b0);
        beat(8'h00, 1'b0);
        beat(8'h81, 1'b1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL faulty_done got %b exp 1", done); end
        checks++; if (fway !== 8'h85) begin errors++; $display("FAIL faulty_fway got %h exp 85", fway); end
        checks++; if (fidx !== 2'd1) begin errors++; $display("FAIL faulty_fidx got %0d exp 1", fidx); end
        checks++; if (fcnt !== 3'd2) begin errors++; $display("FAIL faulty_fcnt got %0d exp 2", fcnt); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL faulty_pass got %b exp 0", pass); end
        @(negedge clk);
    endtask

    // Six clean beats move the index to 6 (wraps to 2), then nine faulty
    // beats push the 3-bit count past its all-ones limit.
    task automatic test_saturate_wrap();
        start_pulse();
        for (int i = 0; i < 6; i++) beat(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) beat(8'h02, 1'b0);
        beat(8'h02, 1'b1);
        checks++; if (fidx !== 2'd2) begin errors++; $display("FAIL sat_fidx got %0d exp 2", fidx); end
        checks++; if (fcnt !== 3'd7) begin errors++; $display("FAIL sat_fcnt got %0d exp 7", fcnt); end
        checks++; if (fway !== 8'h02) begin errors++; $display("FAIL sat_fway got %h exp 02", fway); end
        @(negedge clk);
    endtask

    task automatic test_gapped();
        start_pulse();
        for (int i = 0; i < 3; i++) begin
            beat(8'h00, 1'b0);
            repeat (2) @(negedge clk);
        end
        eoc = 1'b1;
        @(negedge clk);
        eoc = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_stray_eoc_done got %b exp 0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_stray_eoc_busy got %b exp 1", busy); end
        @(negedge clk);
        beat(8'h00, 1'b1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done got %b exp 1", done); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL gap_pass got %b exp 1", pass); end
        @(negedge clk);
    endtask

    task automatic test_start_during_run();
        start_pulse();
        beat(8'h10, 1'b0);
        start_pulse();
        checks++; if (st !== 2'd1) begin errors++; $display("FAIL mid_start_state got %0d exp 1", st); end
        beat(8'h20, 1'b1);
        checks++; if (fway !== 8'h30) begin errors++; $display("FAIL mid_start_fway got %h exp 30", fway); end
        checks++; if (fcnt !== 3'd2) begin errors++; $display("FAIL mid_start_fcnt got %0d exp 2", fcnt); end
        checks++; if (fidx !== 2'd0) begin errors++; $display("FAIL mid_start_fidx got %0d exp 0", fidx); end
        // Start presented during DONE is dropped as well.
        start_pulse();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_start_busy got %b exp 0", busy); end
        checks++; if (fway !== 8'h30) begin errors++; $display("FAIL done_start_hold got %h exp 30", fway); end
        start_pulse();
        checks++; if (fway !== 8'h00) begin errors++; $display("FAIL restart_fway got %h exp 00", fway); end
        checks++; if (fcnt !== 3'd0) begin errors++; $display("FAIL restart_fcnt got %0d exp 0", fcnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b exp 1", busy); end
        beat(8'h00, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        logic seen_done;
        start_pulse();
        beat(8'h00, 1'b0);
`ifdef AXI_LLC_PLRU_BIST_TIMEOUT_EN
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL timeout_latency got %0d exp 16", n); end
        checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", tmo); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL timeout_pass got %b exp 0", pass); end
        @(negedge clk);
`else
        seen_done = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) seen_done = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL no_timeout_busy got abort exp busy for %0d cycles", n); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL no_timeout_flag got %b exp 0", tmo); end
        beat(8'h00, 1'b1);
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_run();
        logic seen_done;
        start_pulse();
        beat(8'h04, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", busy); end
        checks++; if (fway !== 8'h00) begin errors++; $display("FAIL arst_fway got %h exp 00", fway); end
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done = 1'b1;
            if (i == 1) rst = 1'b0;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL arst_done got pulse exp none"); end
        checks++; if (st !== 2'd0) begin errors++; $display("FAIL arst_state got %0d exp 0", st); end
        checks++; if (fcnt !== 3'd0) begin errors++; $display("FAIL arst_fcnt got %0d exp 0", fcnt); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_faulty();
        test_saturate_wrap();
        test_gapped();
        test_start_during_run();
        test_timeout();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
